k423_wb_stage: RTL

Writeback stage of the k423 core, directly downstream of the execute stage. It registers the execute-stage result, waits for the data-memory read response on loads, and aligns and sign/zero-extends the load data. It then drives the single register-file write port and advertises readiness back to the execute stage through the valid/ready pipeline handshake.

---
 rtl/k423_wb_pkg.sv | 29 ++
 rtl/k423_wb_if.sv | 53 +++++
 rtl/k423_wb_ldext.sv | 25 ++
 rtl/k423_wb_stage.sv | 84 ++++++++
 4 files changed

// File: rtl/k423_wb_pkg.sv
// Shared types for the k423 writeback stage: load sizes, FSM states and the
// captured-instruction context.
package k423_wb_pkg;

  localparam int WB_XLEN   = 32;
  localparam int WB_ADDR_W = 32;
  localparam int WB_RIDX_W = 5;

  typedef enum logic [1:0] {LS_B = 2'b00, LS_H = 2'b01, LS_W = 2'b10} ls_size_e;

  typedef enum logic [1:0] {IDLE, RET, LDW, LDR} wb_state_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] pc;
    logic                 rd_vld;
    logic [WB_RIDX_W-1:0] idx;
    logic [WB_XLEN-1:0]   rd;
    logic                 load;
    logic                 is_unsigned;
    ls_size_e             size;
    logic [1:0]           lsb;
  } wb_ctx_t;

  // x0 is hardwired zero, so a write to it is suppressed.
  function automatic logic wb_writes(input logic rd_vld, input logic [WB_RIDX_W-1:0] idx);
    return rd_vld & (idx != '0);
  endfunction

endpackage

// File: rtl/k423_wb_if.sv
// Execute->writeback handshake, data-memory response and register-file write
// port. Forwarding signals exist only when K423_WB_FWD_EN is defined.
interface k423_wb_if
  import k423_wb_pkg::*;
#(
  parameter int XLEN   = WB_XLEN,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int RIDX_W = WB_RIDX_W
);
  logic              ex_stage_vld_i;
  logic              wb_stage_rdy_o;
  logic [ADDR_W-1:0] ex_pc_i;
  logic              ex_rd_vld_i;
  logic [RIDX_W-1:0] ex_rd_idx_i;
  logic [XLEN-1:0]   ex_rd_i;
  logic              ex_rd_load_i;
  logic              ex_rd_load_unsigned_i;
  ls_size_e          ex_rd_load_size_i;
  logic [1:0]        ex_mem_addr_lsb_i;
  logic              mem_rsp_vld_i;
  logic [XLEN-1:0]   mem_rsp_rdata_i;
  logic              wb_rf_wen_o;
  logic [RIDX_W-1:0] wb_rf_idx_o;
  logic [XLEN-1:0]   wb_rf_wdata_o;
  logic [ADDR_W-1:0] wb_pc_o;
  logic              wb_retire_o;
`ifdef K423_WB_FWD_EN
  logic              wb_fwd_vld_o;
  logic [RIDX_W-1:0] wb_fwd_idx_o;
  logic [XLEN-1:0]   wb_fwd_data_o;
  logic              wb_fwd_pend_o;
`endif

  modport slave (
    input  ex_stage_vld_i, ex_pc_i, ex_rd_vld_i, ex_rd_idx_i, ex_rd_i, ex_rd_load_i,
           ex_rd_load_unsigned_i, ex_rd_load_size_i, ex_mem_addr_lsb_i,
           mem_rsp_vld_i, mem_rsp_rdata_i,
`ifdef K423_WB_FWD_EN
    output wb_fwd_vld_o, wb_fwd_idx_o, wb_fwd_data_o, wb_fwd_pend_o,
`endif
    output wb_stage_rdy_o, wb_rf_wen_o, wb_rf_idx_o, wb_rf_wdata_o, wb_pc_o, wb_retire_o
  );

  modport master (
    output ex_stage_vld_i, ex_pc_i, ex_rd_vld_i, ex_rd_idx_i, ex_rd_i, ex_rd_load_i,
           ex_rd_load_unsigned_i, ex_rd_load_size_i, ex_mem_addr_lsb_i,
           mem_rsp_vld_i, mem_rsp_rdata_i,
`ifdef K423_WB_FWD_EN
    input  wb_fwd_vld_o, wb_fwd_idx_o, wb_fwd_data_o, wb_fwd_pend_o,
`endif
    input  wb_stage_rdy_o, wb_rf_wen_o, wb_rf_idx_o, wb_rf_wdata_o, wb_pc_o, wb_retire_o
  );
endinterface

// File: rtl/k423_wb_ldext.sv
// Combinational load-lane select and sign/zero extension; kept standalone so an
// MMIO read path can share it.
module k423_wb_ldext
  import k423_wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      lsb_i,
  input  ls_size_e        size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);
  logic [XLEN-1:0] lane;

  // A half at lsb=3 shifts zeros into bits [15:8]; misalignment is not trapped here.
  always_comb begin
    lane = rdata_i >> {lsb_i, 3'b000};
    case (size_i)
      LS_B:    data_o = {{(XLEN-8){~unsigned_i & lane[7]}}, lane[7:0]};
      LS_H:    data_o = {{(XLEN-16){~unsigned_i & lane[15]}}, lane[15:0]};
      default: data_o = lane;
    endcase
  end
endmodule

// File: rtl/k423_wb_stage.sv
// k423 writeback stage: registers the execute result, waits for load data,
// extends it and drives the register-file write port. Bypass outputs under K423_WB_FWD_EN.
module k423_wb_stage
  import k423_wb_pkg::*;
#(
  parameter int XLEN   = WB_XLEN,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int RIDX_W = WB_RIDX_W
) (
  input logic      clk_i,
  input logic      rst_i,
  k423_wb_if.slave wb
);
  wb_state_e         state_q;
  wb_ctx_t           ctx_q, ctx_d;
  logic [XLEN-1:0]   data_q;
  logic [XLEN-1:0]   ld_data;
  logic [RIDX_W-1:0] idx_w;
  logic [ADDR_W-1:0] pc_w;
  logic              rdy, acc, retiring;

  assign rdy      = (state_q != LDW);
  assign acc      = wb.ex_stage_vld_i & rdy;
  assign retiring = (state_q == RET) | (state_q == LDR);

  always_comb begin
    ctx_d             = '0;
    ctx_d.pc          = wb.ex_pc_i;
    ctx_d.rd_vld      = wb.ex_rd_vld_i;
    ctx_d.idx         = wb.ex_rd_idx_i;
    ctx_d.rd          = wb.ex_rd_i;
    ctx_d.load        = wb.ex_rd_load_i;
    ctx_d.is_unsigned = wb.ex_rd_load_unsigned_i;
    ctx_d.size        = wb.ex_rd_load_size_i;
    ctx_d.lsb         = wb.ex_mem_addr_lsb_i;
  end

  k423_wb_ldext #(.XLEN(XLEN)) u_ldext (
    .rdata_i    (wb.mem_rsp_rdata_i),
    .lsb_i      (ctx_q.lsb),
    .size_i     (ctx_q.size),
    .unsigned_i (ctx_q.is_unsigned),
    .data_o     (ld_data)
  );

  // Responses outside LDW are stale and fall through the default branch untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ctx_q   <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        LDW: if (ctx_q.load & wb.mem_rsp_vld_i) begin
          data_q  <= ld_data;
          state_q <= LDR;
        end
        default: if (acc) begin
          ctx_q   <= ctx_d;
          state_q <= wb.ex_rd_load_i ? LDW : RET;
        end else begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign idx_w = ctx_q.idx;
  assign pc_w  = ctx_q.pc;

  assign wb.wb_stage_rdy_o = rdy;
  assign wb.wb_retire_o    = retiring;
  assign wb.wb_rf_wen_o    = retiring & wb_writes(ctx_q.rd_vld, ctx_q.idx);
  assign wb.wb_rf_idx_o    = idx_w;
  assign wb.wb_rf_wdata_o  = (state_q == LDR) ? data_q : ctx_q.rd;
  assign wb.wb_pc_o        = pc_w;

`ifdef K423_WB_FWD_EN
  assign wb.wb_fwd_vld_o  = retiring & wb_writes(ctx_q.rd_vld, ctx_q.idx);
  assign wb.wb_fwd_idx_o  = idx_w;
  assign wb.wb_fwd_data_o = (state_q == LDR) ? data_q : ctx_q.rd;
  assign wb.wb_fwd_pend_o = (state_q == LDW) & wb_writes(ctx_q.rd_vld, ctx_q.idx);
`endif
endmodule
